// File: rtl/sha256_msg_packer.sv
// Packs a byte stream into 55-byte chunks for a SHA-256 core, closes every message with a
// zero-length terminator chunk and captures the digest the core returns.
module sha256_msg_packer (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [7:0]   in_data_i,
  input  logic         in_last_i,
  output logic         in_ready_o,
  input  logic         start_empty_i,
  output logic         msg_valid_o,
  output logic [5:0]   byte_valid_o,
  output logic [439:0] msg_word_o,
  input  logic         hash_done_i,
  input  logic [255:0] fin_hash_i,
  output logic         digest_valid_o,
  output logic [255:0] digest_o,
  output logic         busy_o
);

  localparam int unsigned MaxBytes = 55;
  localparam int unsigned WordW    = 8 * MaxBytes;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StSend,
    StGap,
    StTerm,
    StWaitHash
  } state_e;

  state_e             state_q;
  logic [5:0]         cnt_q;
  logic               last_q;
  logic [WordW-1:0]   buf_q;
  logic               in_ready_q;
  logic               msg_valid_q;
  logic [5:0]         byte_valid_q;
  logic [WordW-1:0]   msg_word_q;
  logic               digest_valid_q;
  logic [255:0]       digest_q;
  logic               busy_q;

  logic               accept;
  logic [5:0]         cnt_inc;
  logic               chunk_full;
  logic [8:0]         shamt;
  logic [WordW-1:0]   buf_wr;

  // Byte i lands at bits [439-8i -: 8]; the buffer is zero wherever no byte has been written.
  always_comb begin
    accept     = in_valid_i & in_ready_q;
    cnt_inc    = cnt_q + 6'd1;
    chunk_full = (cnt_inc == 6'(MaxBytes));
    shamt      = 9'(8 * (MaxBytes - 1)) - {cnt_q, 3'b000};
    buf_wr     = buf_q | (WordW'(in_data_i) << shamt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      last_q         <= 1'b0;
      buf_q          <= '0;
      in_ready_q     <= 1'b0;
      msg_valid_q    <= 1'b0;
      byte_valid_q   <= '0;
      msg_word_q     <= '0;
      digest_valid_q <= 1'b0;
      digest_q       <= '0;
      busy_q         <= 1'b0;
    end else begin
      msg_valid_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StFill: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            buf_q  <= buf_wr;
            cnt_q  <= cnt_inc;
            busy_q <= 1'b1;
            if (in_last_i || chunk_full) begin
              state_q      <= StSend;
              in_ready_q   <= 1'b0;
              last_q       <= in_last_i;
              msg_valid_q  <= 1'b1;
              byte_valid_q <= cnt_inc;
              msg_word_q   <= buf_wr;
            end else begin
              state_q <= StFill;
            end
          end else if (state_q == StIdle && start_empty_i && !in_valid_i) begin
            // Zero-length message: skip straight to the terminator path.
            state_q    <= StGap;
            in_ready_q <= 1'b0;
            last_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StSend: begin
          state_q <= StGap;
          buf_q   <= '0;
          cnt_q   <= '0;
        end
        StGap: begin
          if (last_q) begin
            state_q      <= StTerm;
            msg_valid_q  <= 1'b1;
            byte_valid_q <= '0;
            msg_word_q   <= '0;
          end else begin
            state_q    <= StFill;
            in_ready_q <= 1'b1;
          end
        end
        StTerm: begin
          state_q <= StWaitHash;
          last_q  <= 1'b0;
        end
        StWaitHash: begin
          if (hash_done_i) begin
            state_q        <= StIdle;
            digest_q       <= fin_hash_i;
            digest_valid_q <= 1'b1;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign msg_valid_o    = msg_valid_q;
  assign byte_valid_o   = byte_valid_q;
  assign msg_word_o     = msg_word_q;
  assign digest_valid_o = digest_valid_q;
  assign digest_o       = digest_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Directed bench for sha256_msg_packer: a table of messages is streamed in, chunks are compared
// against a packing model, and the bench plays the hash core.
module tb_sha256_msg_packer;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic [7:0]   in_data_i = '0;
  logic         in_last_i = 1'b0;
  logic         in_ready_o;
  logic         start_empty_i = 1'b0;
  logic         msg_valid_o;
  logic [5:0]   byte_valid_o;
  logic [439:0] msg_word_o;
  logic         hash_done_i = 1'b0;
  logic [255:0] fin_hash_i = '0;
  logic         digest_valid_o;
  logic [255:0] digest_o;
  logic         busy_o;

  sha256_msg_packer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .in_ready_o     (in_ready_o),
    .start_empty_i  (start_empty_i),
    .msg_valid_o    (msg_valid_o),
    .byte_valid_o   (byte_valid_o),
    .msg_word_o     (msg_word_o),
    .hash_done_i    (hash_done_i),
    .fin_hash_i     (fin_hash_i),
    .digest_valid_o (digest_valid_o),
    .digest_o       (digest_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string        text;
    int           len;
    logic [7:0]   base;
    bit           empty;
    bit           se_too;
    int           n_data;
    logic [255:0] dig;
  } vec_t;

  vec_t vecs[8];
  int   nvec = 0;
  int   nerr = 0;

  // Monitor state, written only by the monitor process.
  logic [5:0]   got_bv[$];
  logic [439:0] got_w[$];
  int           term_cnt = 0;
  int           dv_cnt = 0;
  int           proto_err = 0;
  logic         prev_mv = 1'b0;

  logic [7:0]   src[$];

  always @(negedge clk_i) begin
    if (msg_valid_o) begin
      if (prev_mv || in_ready_o) proto_err++;
      got_bv.push_back(byte_valid_o);
      got_w.push_back(msg_word_o);
      if (byte_valid_o == 6'd0) term_cnt++;
    end
    if (digest_valid_o) dv_cnt++;
    prev_mv = msg_valid_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_bytes(input bit with_last, input bit se_too);
    int idx = 0;
    int cycles = 0;
    logic acc;
    start_empty_i = se_too;
    while (idx < src.size() && cycles < 3000) begin
      in_valid_i = 1'b1;
      in_data_i  = src[idx];
      in_last_i  = with_last && (idx == src.size() - 1);
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) idx++;
      cycles++;
    end
    in_valid_i    = 1'b0;
    in_last_i     = 1'b0;
    start_empty_i = 1'b0;
    if (cycles >= 3000) chk("drive_timeout", 512'(idx), 512'(src.size()));
  endtask

  task automatic load_src(input vec_t v, input int n);
    src.delete();
    for (int i = 0; i < n; i++) begin
      if (v.text.len() != 0) src.push_back(v.text.getc(i));
      else src.push_back(v.base + 8'(i));
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int base = got_bv.size();
    int t0 = term_cnt;
    int d0 = dv_cnt;
    int p0 = proto_err;
    int n = 0;
    int pos = 0;
    int k = 0;
    int rem;
    int nb;
    logic [439:0] w;
    string tag = $sformatf("v%0d", id);

    if (v.empty) begin
      start_empty_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_empty_i = 1'b0;
    end else begin
      load_src(v, v.len);
      drive_bytes(1'b1, v.se_too);
    end

    while (term_cnt == t0 && n < 300) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 300) chk({tag, "_term_timeout"}, 512'(term_cnt - t0), 512'(1));
    repeat (2) @(posedge clk_i);
    #1;
    hash_done_i = 1'b1;
    fin_hash_i  = v.dig;
    @(posedge clk_i);
    #1;
    hash_done_i = 1'b0;
    fin_hash_i  = {8{32'hDEAD_BEEF}};
    repeat (3) @(posedge clk_i);
    #1;

    chk({tag, "_chunks"}, 512'(got_bv.size() - base), 512'(v.n_data + 1));
    if (got_bv.size() - base == v.n_data + 1) begin
      rem = v.len;
      while (rem > 0) begin
        nb = (rem > 55) ? 55 : rem;
        w = '0;
        for (int j = 0; j < nb; j++) w = w | (440'(src[pos + j]) << (8 * (54 - j)));
        chk($sformatf("%s_bv%0d", tag, k), 512'(got_bv[base + k]), 512'(nb));
        chk($sformatf("%s_word%0d", tag, k), 512'(got_w[base + k]), 512'(w));
        pos += nb;
        rem -= nb;
        k++;
      end
      chk({tag, "_term_bv"}, 512'(got_bv[base + k]), 512'(0));
      chk({tag, "_term_word"}, 512'(got_w[base + k]), 512'(0));
    end
    chk({tag, "_term_count"}, 512'(term_cnt - t0), 512'(1));
    chk({tag, "_digest_pulses"}, 512'(dv_cnt - d0), 512'(1));
    chk({tag, "_digest"}, 512'(digest_o), 512'(v.dig));
    chk({tag, "_protocol"}, 512'(proto_err - p0), 512'(0));
    chk({tag, "_idle"}, 512'({busy_o, in_ready_o}), 512'(2'b01));
  endtask

  initial begin
    int c0;
    int d0;
    vecs[0] = '{"abc", 3, 8'h00, 1'b0, 1'b0, 1,
                256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
    vecs[1] = '{"", 0, 8'h00, 1'b1, 1'b0, 0,
                256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
    vecs[2] = '{"", 128, 8'h00, 1'b0, 1'b0, 3, {8{32'h1111_2222}}};
    vecs[3] = '{"", 55, 8'h40, 1'b0, 1'b0, 1, {8{32'h3333_4444}}};
    vecs[4] = '{"", 110, 8'h80, 1'b0, 1'b0, 2, {8{32'h5555_6666}}};
    vecs[5] = '{"", 1, 8'h5A, 1'b0, 1'b1, 1, {8{32'h7777_8888}}};
    vecs[6] = '{"", 56, 8'h10, 1'b0, 1'b0, 2, {8{32'h9999_AAAA}}};
    vecs[7] = '{"The quick brown fox jumps over the lazy dog", 43, 8'h00, 1'b0, 1'b0, 1,
                256'hd7a8fbb307d7809469ca9abcb0082e4f8d5651e46d3cdb762d02d0bf37c9e592};

    #12;
    chk("rst_in_ready", 512'(in_ready_o), 512'(0));
    chk("rst_outs", 512'({msg_valid_o, byte_valid_o, digest_valid_o, busy_o}), 512'(0));
    chk("rst_word", 512'(msg_word_o), 512'(0));
    chk("rst_digest", 512'(digest_o), 512'(0));
    #11 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("post_rst_ready", 512'({busy_o, in_ready_o}), 512'(2'b01));

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Late hash_done while idle must not disturb the held digest.
    d0 = dv_cnt;
    fin_hash_i  = {8{32'h0BAD_F00D}};
    hash_done_i = 1'b1;
    @(posedge clk_i);
    #1;
    hash_done_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("stray_done_pulse", 512'(dv_cnt - d0), 512'(0));
    chk("stray_done_digest", 512'(digest_o), 512'(vecs[6].dig));

    // Abort a message after 20 bytes with an asynchronous reset.
    c0 = got_bv.size();
    load_src(vecs[7], 20);
    drive_bytes(1'b0, 1'b0);
    chk("partial_no_chunk", 512'(got_bv.size() - c0), 512'(0));
    chk("partial_busy", 512'(busy_o), 512'(1));
    #3 rst_ni = 1'b0;
    #1;
    chk("midrst_outs",
        512'({in_ready_o, msg_valid_o, byte_valid_o, digest_valid_o, busy_o}), 512'(0));
    chk("midrst_word", 512'(msg_word_o), 512'(0));
    chk("midrst_digest", 512'(digest_o), 512'(0));
    #10 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("midrst_no_term", 512'(got_bv.size() - c0), 512'(0));
    run_vec(vecs[7], 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
